// File: rtl/core_regfile_mp_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package core_regfile_mp_pkg;

  // Default data width of one architectural register
  localparam int XLEN_DEF = 32;

  // Register 0 is hardwired to zero: never written, never pending
  localparam int REG_ZERO = 0;

  // Address width needed to index n registers
  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/core_regfile_mp_if.sv
// Register-file bus: operand reads, write-back commits, issue/flush scoreboard traffic.
// Latency: wires only; timing is set by the attached modules.
// Backpressure: none; dispatch stalls itself on iss_waw / rd_busy.
interface core_regfile_mp_if
  import core_regfile_mp_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NWR  = 1
);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                iss_waw;
  logic                flush;
  logic [AW:0]         pend_cnt;

  // Pipeline side: decode, dispatch, write-back and the flush controller
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, iss_waw, pend_cnt
  );

  // Register-file side
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, iss_waw, pend_cnt
  );

endinterface

// File: rtl/core_regfile_mp_sb.sv
// Pending scoreboard: one bit per register, set on issue, cleared on write-back or flush.
// Latency: pending bits and pend_cnt update at the clock edge; iss_waw is combinational.
// Backpressure: none; iss_waw only reports the hazard, the issue is never blocked here.
module core_regfile_sb
  import core_regfile_mp_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = addr_w(NREG)
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic [NREG-1:0] wr_hit,
  input  logic            flush,
  output logic [NREG-1:0] pend,
  output logic            iss_waw,
  output logic [AW:0]     pend_cnt
);

  logic [NREG-1:0] pend_q, pend_d;
  logic [AW:0]     cnt_q, cnt_d;

  // Next pending state: flush beats issue beats write-back; a new producer supersedes the old
  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < NREG; r++) begin
      if (flush) begin
        pend_d[r] = 1'b0;
      end else if (iss_en && iss_addr == AW'(r)) begin
        pend_d[r] = 1'b1;
      end else if (wr_hit[r]) begin
        pend_d[r] = 1'b0;
      end
    end
    pend_d[REG_ZERO] = 1'b0;
    cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, pend_d[r]};
    end
  end

  // Pending bits and their population count move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // WAW check uses the registered bit, before any same-cycle write-back
  assign iss_waw  = iss_en & pend_q[iss_addr];
  assign pend     = pend_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/core_regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and pending scoreboard.
// Latency: reads combinational (0 cycles); writes commit at the clock edge.
// Backpressure: none; hazards are reported via rd_busy/iss_waw for dispatch to stall on.
module core_regfile_mp
  import core_regfile_mp_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = 32,
  parameter int AW     = addr_w(NREG),
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
)(
  input  logic             clk,
  input  logic             rst_n,
  core_regfile_mp_if.slave rf
);

  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:0]           wr_hit;
  logic [NREG-1:0]           pend;

  // Write-port arbitration: later ports overwrite earlier ones, so the highest index wins
  always_comb begin
    regs_d = regs_q;
    wr_hit = '0;
    for (int j = 0; j < NWR; j++) begin
      if (rf.wr_en[j] && rf.wr_addr[j*AW +: AW] != AW'(REG_ZERO)) begin
        regs_d[rf.wr_addr[j*AW +: AW]] = rf.wr_data[j*XLEN +: XLEN];
        wr_hit[rf.wr_addr[j*AW +: AW]] = 1'b1;
      end
    end
  end

  // Register storage; entry 0 is never loaded so it stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes: stored value and pending bit, overridden by an in-flight write when bypassing
  always_comb begin
    rf.rd_data = '0;
    rf.rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rf.rd_data[i*XLEN +: XLEN] = regs_q[rf.rd_addr[i*AW +: AW]];
      rf.rd_busy[i]              = pend[rf.rd_addr[i*AW +: AW]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (rf.wr_en[j] && rf.wr_addr[j*AW +: AW] == rf.rd_addr[i*AW +: AW]) begin
            rf.rd_data[i*XLEN +: XLEN] = rf.wr_data[j*XLEN +: XLEN];
            rf.rd_busy[i]              = 1'b0;
          end
        end
      end
      if (rf.rd_addr[i*AW +: AW] == AW'(REG_ZERO)) begin
        rf.rd_data[i*XLEN +: XLEN] = '0;
        rf.rd_busy[i]              = 1'b0;
      end
    end
  end

  core_regfile_sb #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (rf.iss_en),
    .iss_addr (rf.iss_addr),
    .wr_hit   (wr_hit),
    .flush    (rf.flush),
    .pend     (pend),
    .iss_waw  (rf.iss_waw),
    .pend_cnt (rf.pend_cnt)
  );

endmodule
